handle_requester: RTL
=====================

Name: handle_requester

Overview:
- Initiator side of the handle-command protocol. Turns host-level ALLOC / FREE / LOOKUP requests into handle-command bus cycles (op/address/data) toward the handle translation unit, and returns handle, base and error to the host.
- Sits between the core's handle-management logic and the handle translation unit. It owns the handle-command bus only while a request is in flight; otherwise the bus idles at NOP.

Parameters:
- ADDR_WIDTH, 16, width of bus address and data.
- HNDL_WIDTH, 4, handle id width. Id all-ones is reserved (the "get available id" selector), so usable handles are 0 to 2^HNDL_WIDTH-2.
- BASE_WIDTH, ADDR_WIDTH-HNDL_WIDTH-1, width of a mapped base address.

Ports:
- i_clock, in, 1: clock, rising edge.
- i_reset_n, in, 1: reset, synchronous, active-low.
- i_req_valid, in, 1: host request valid.
- o_req_ready, out, 1: host request accepted when valid&ready.
- i_req_cmd, in, 2: 0=ALLOC, 1=FREE, 2=LOOKUP, 3=reserved.
- i_req_handle, in, HNDL_WIDTH: handle for FREE / LOOKUP.
- i_req_base, in, BASE_WIDTH: base address for ALLOC.
- o_rsp_valid, out, 1: response valid; held until i_rsp_ready.
- i_rsp_ready, in, 1: host accepts response.
- o_rsp_handle, out, HNDL_WIDTH: allocated or echoed handle.
- o_rsp_base, out, BASE_WIDTH: looked-up or mapped base.
- o_rsp_error, out, 1: request failed.
- o_op, out, 3: bus op, 0=NOP, 1=READ, 2=WRITE.
- o_address, out, ADDR_WIDTH: bus address.
- o_data, out, ADDR_WIDTH: bus write data.
- i_data, in, ADDR_WIDTH: bus response data, valid in the same cycle as the READ.

Behaviour:
- Reset (i_reset_n=0 at a rising edge): state=IDLE; o_op=0, o_address=0, o_data=0, o_rsp_valid=0, o_rsp_error=0, o_rsp_handle=0, o_rsp_base=0, o_req_ready=0.
- Reset mid-operation aborts the command at once; no further bus cycle is issued.
- All outputs are registered.
- Handle-command address: bits [ADDR_WIDTH-1 : ADDR_WIDTH-HNDL_WIDTH-1] all ones, middle bits zero, low HNDL_WIDTH bits = handle id.
- Get-available-id address: the same, with the low bits all ones.
- Bus cycle rule:
  - Each command occupies exactly one cycle with o_op non-NOP.
  - READ data is sampled from i_data at the rising edge that ends that cycle.
  - o_op returns to NOP in every non-command cycle.
- FSM states: IDLE, GET_ID, MAP, FREE, LOOKUP, RESP.
  - IDLE: o_req_ready=1. On valid&ready, latch cmd, handle and base, then branch:
    - ALLOC with base==0 -> RESP, error=1 (a zero write would invalidate).
    - FREE/LOOKUP with handle all-ones -> RESP, error=1.
    - cmd 3 -> RESP, error=1.
    - otherwise ALLOC -> GET_ID, FREE -> FREE, LOOKUP -> LOOKUP.
    - No bus cycle is issued for error cases.
  - GET_ID: o_op=READ at the get-id address.
    - Sampled id[HNDL_WIDTH-1:0] all-ones means no free handle -> RESP, error=1.
    - Else latch id -> MAP.
  - MAP: o_op=WRITE, address = handle address of latched id, o_data = zero-extended base -> RESP, rsp_handle=id, rsp_base=base, error=0.
  - FREE: o_op=WRITE, handle address, o_data=0 -> RESP, error=0, rsp_handle=handle, rsp_base=0.
  - LOOKUP: o_op=READ, handle address.
    - rsp_base = i_data[BASE_WIDTH-1:0].
    - Sampled base==0 (unmapped) sets error=1.
    - rsp_handle=handle.
  - RESP: o_rsp_valid=1, o_req_ready=0. On i_rsp_ready -> IDLE and clear o_rsp_valid the next cycle. Response fields are stable while valid and not ready.
- o_req_ready is 0 in every state except IDLE. Back-to-back requests: the earliest next accept is the cycle after the response handshake.
- Latency, acceptance edge to o_rsp_valid:
  - ALLOC: 3 cycles.
  - FREE and LOOKUP: 2 cycles.
  - Immediate errors: 1 cycle.
- o_address and o_data hold their last value while o_op=NOP; they are don't-care for the responder.

Test Plan:
- Reset: hold i_reset_n=0 for 2 cycles with i_req_valid=1 -> all outputs 0, no accept. Assert reset while in GET_ID -> next cycle o_op=0, state IDLE.
- ALLOC base=0x123, responder returns id 5 -> bus sequence:
  - READ at 0xF80F;
  - WRITE at 0xF805, data 0x0123;
  - o_rsp_valid 3 cycles after accept with handle=5, base=0x123, error=0.
- ALLOC with responder returning id 0xF -> no WRITE issued; response error=1. ALLOC base=0 -> no bus cycle; error=1 after 1 cycle.
- LOOKUP handle 5 with i_data=0x0123 -> READ at 0xF805; rsp_base=0x123, error=0. LOOKUP handle 7 with i_data=0 -> error=1.
- FREE handle 5 -> single WRITE at 0xF805, data 0; rsp_handle=5, error=0. FREE handle 0xF -> no bus cycle, error=1.
- Backpressure: hold i_rsp_ready=0 for 4 cycles -> o_rsp_valid and fields stable, o_req_ready=0, o_op=NOP. Release -> IDLE; a back-to-back ALLOC is accepted the following cycle.

Source files
------------

// File: rtl/handle_requester.sv
// handle_requester: initiator for the handle-command bus.
// Turns host ALLOC / FREE / LOOKUP requests into one-cycle READ/WRITE bus
// commands toward the handle translation unit and returns handle/base/error.
module handle_requester #(
    parameter int ADDR_WIDTH = 16,
    parameter int HNDL_WIDTH = 4,
    parameter int BASE_WIDTH = ADDR_WIDTH - HNDL_WIDTH - 1
) (
    input  logic                  i_clock,
    input  logic                  i_reset_n,
    input  logic                  i_req_valid,
    output logic                  o_req_ready,
    input  logic [1:0]            i_req_cmd,
    input  logic [HNDL_WIDTH-1:0] i_req_handle,
    input  logic [BASE_WIDTH-1:0] i_req_base,
    output logic                  o_rsp_valid,
    input  logic                  i_rsp_ready,
    output logic [HNDL_WIDTH-1:0] o_rsp_handle,
    output logic [BASE_WIDTH-1:0] o_rsp_base,
    output logic                  o_rsp_error,
    output logic [2:0]            o_op,
    output logic [ADDR_WIDTH-1:0] o_address,
    output logic [ADDR_WIDTH-1:0] o_data,
    input  logic [ADDR_WIDTH-1:0] i_data
);

    localparam logic [2:0] OP_NOP   = 3'd0;
    localparam logic [2:0] OP_READ  = 3'd1;
    localparam logic [2:0] OP_WRITE = 3'd2;

    localparam logic [1:0] CMD_ALLOC  = 2'd0;
    localparam logic [1:0] CMD_FREE   = 2'd1;
    localparam logic [1:0] CMD_LOOKUP = 2'd2;

    // All-ones id is the "get available id" selector, never a real handle.
    localparam logic [HNDL_WIDTH-1:0] ID_ANY = '1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_GET_ID,
        S_MAP,
        S_FREE,
        S_LOOKUP,
        S_RESP
    } state_t;

    state_t                state_q, state_d;
    logic [HNDL_WIDTH-1:0] handle_q, handle_d;
    logic [BASE_WIDTH-1:0] base_q, base_d;
    logic [2:0]            op_q, op_d;
    logic [ADDR_WIDTH-1:0] address_q, address_d;
    logic [ADDR_WIDTH-1:0] data_q, data_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic                  rsp_error_q, rsp_error_d;
    logic [HNDL_WIDTH-1:0] rsp_handle_q, rsp_handle_d;
    logic [BASE_WIDTH-1:0] rsp_base_q, rsp_base_d;
    logic                  req_ready_q, req_ready_d;
    logic                  bad_req;

    // Bits above the base field never carry meaning in a response.
    logic unused_data;
    assign unused_data = ^i_data[ADDR_WIDTH-1:BASE_WIDTH];

    // Command address: top HNDL_WIDTH+1 bits set, middle zero, id in the low bits.
    function automatic logic [ADDR_WIDTH-1:0] cmd_addr(input logic [HNDL_WIDTH-1:0] id);
        logic [ADDR_WIDTH-1:0] a;
        a = '0;
        a[ADDR_WIDTH-1:ADDR_WIDTH-HNDL_WIDTH-1] = '1;
        a[HNDL_WIDTH-1:0] = id;
        return a;
    endfunction

    // Next-state and next-output logic; bus outputs are computed for the state being entered.
    always_comb begin
        state_d      = state_q;
        handle_d     = handle_q;
        base_d       = base_q;
        op_d         = OP_NOP;
        address_d    = address_q;
        data_d       = data_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_error_d  = rsp_error_q;
        rsp_handle_d = rsp_handle_q;
        rsp_base_d   = rsp_base_q;
        req_ready_d  = 1'b0;
        bad_req      = 1'b0;

        case (state_q)
            S_IDLE: begin
                req_ready_d = 1'b1;
                if (i_req_valid && req_ready_q) begin
                    req_ready_d = 1'b0;
                    handle_d    = i_req_handle;
                    base_d      = i_req_base;
                    case (i_req_cmd)
                        CMD_ALLOC: begin
                            // Mapping base zero would read back as "unmapped".
                            if (i_req_base == '0) begin
                                bad_req = 1'b1;
                            end else begin
                                state_d   = S_GET_ID;
                                op_d      = OP_READ;
                                address_d = cmd_addr(ID_ANY);
                            end
                        end
                        CMD_FREE: begin
                            if (i_req_handle == ID_ANY) begin
                                bad_req = 1'b1;
                            end else begin
                                state_d   = S_FREE;
                                op_d      = OP_WRITE;
                                address_d = cmd_addr(i_req_handle);
                                data_d    = '0;
                            end
                        end
                        CMD_LOOKUP: begin
                            if (i_req_handle == ID_ANY) begin
                                bad_req = 1'b1;
                            end else begin
                                state_d   = S_LOOKUP;
                                op_d      = OP_READ;
                                address_d = cmd_addr(i_req_handle);
                            end
                        end
                        default: bad_req = 1'b1;
                    endcase
                    if (bad_req) begin
                        state_d      = S_RESP;
                        rsp_valid_d  = 1'b1;
                        rsp_error_d  = 1'b1;
                        rsp_handle_d = i_req_handle;
                        rsp_base_d   = '0;
                    end
                end
            end
            S_GET_ID: begin
                if (i_data[HNDL_WIDTH-1:0] == ID_ANY) begin
                    // Responder has no free handle left.
                    state_d      = S_RESP;
                    rsp_valid_d  = 1'b1;
                    rsp_error_d  = 1'b1;
                    rsp_handle_d = ID_ANY;
                    rsp_base_d   = '0;
                end else begin
                    handle_d  = i_data[HNDL_WIDTH-1:0];
                    state_d   = S_MAP;
                    op_d      = OP_WRITE;
                    address_d = cmd_addr(i_data[HNDL_WIDTH-1:0]);
                    data_d    = {{(ADDR_WIDTH-BASE_WIDTH){1'b0}}, base_q};
                end
            end
            S_MAP: begin
                state_d      = S_RESP;
                rsp_valid_d  = 1'b1;
                rsp_error_d  = 1'b0;
                rsp_handle_d = handle_q;
                rsp_base_d   = base_q;
            end
            S_FREE: begin
                state_d      = S_RESP;
                rsp_valid_d  = 1'b1;
                rsp_error_d  = 1'b0;
                rsp_handle_d = handle_q;
                rsp_base_d   = '0;
            end
            S_LOOKUP: begin
                state_d      = S_RESP;
                rsp_valid_d  = 1'b1;
                rsp_handle_d = handle_q;
                rsp_base_d   = i_data[BASE_WIDTH-1:0];
                rsp_error_d  = (i_data[BASE_WIDTH-1:0] == '0);
            end
            S_RESP: begin
                if (i_rsp_ready) begin
                    state_d     = S_IDLE;
                    rsp_valid_d = 1'b0;
                    req_ready_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and registered outputs; reset drops any command in flight.
    always_ff @(posedge i_clock) begin
        if (!i_reset_n) begin
            state_q      <= S_IDLE;
            handle_q     <= '0;
            base_q       <= '0;
            op_q         <= OP_NOP;
            address_q    <= '0;
            data_q       <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_error_q  <= 1'b0;
            rsp_handle_q <= '0;
            rsp_base_q   <= '0;
            req_ready_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            handle_q     <= handle_d;
            base_q       <= base_d;
            op_q         <= op_d;
            address_q    <= address_d;
            data_q       <= data_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_error_q  <= rsp_error_d;
            rsp_handle_q <= rsp_handle_d;
            rsp_base_q   <= rsp_base_d;
            req_ready_q  <= req_ready_d;
        end
    end

    assign o_req_ready  = req_ready_q;
    assign o_rsp_valid  = rsp_valid_q;
    assign o_rsp_error  = rsp_error_q;
    assign o_rsp_handle = rsp_handle_q;
    assign o_rsp_base   = rsp_base_q;
    assign o_op         = op_q;
    assign o_address    = address_q;
    assign o_data       = data_q;

endmodule
